clk_rst_ctrl: RTL
=================

# clk_rst_ctrl

PLL bring-up and reset sequencer for the clock subsystem. Holds the PLL in reset for a fixed time and waits for a filtered, synchronized `pll_lock`. Releases per-domain resets in a staged order and monitors lock during operation. Sits beside the PLL wrapper in the clock top, drives its reset input, and feeds the reset inputs of every downstream clock domain.

## Interface
- `HOLD_CYC`, 16: cycles the PLL reset is held asserted per attempt (>=2).
- `LOCK_FILT`, 64: consecutive synchronized-lock-high cycles required before lock is declared (>=1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in lock wait before the attempt fails (<2^16).
- `STAGE_GAP`, 16: cycles between successive domain reset releases (>=1).
- `NUM_DOM`, 4: number of downstream reset domains (1..8).
- `MAX_RETRY`, 3: failed lock attempts before entering fail state (1..15).
- `clkin1  in  1`: reference clock (free-running oscillator); the only clock.
- `pll_rst  in  1`: asynchronous, active-low reset.
- `pll_lock  in  1`: PLL lock, asynchronous to `clkin1`.
- `restart_req  in  1`: single-cycle soft restart request, synchronous to `clkin1`.
- `pll_hold_n  out  1`: active-low PLL reset drive.
- `rst_n_out  out  NUM_DOM`: active-low domain resets; bit 0 is released first.
- `sys_ready  out  1`: high only in RUN.
- `pll_fail  out  1`: high only in FAIL.
- `lock_loss_cnt  out  8`: saturating lock-loss count (see Configuration).

## Operation
- `pll_lock` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- One 16-bit phase counter `cnt`. It is cleared on every state change.
- A 4-bit `retry_cnt` counts failed attempts.
- HOLD:
  - `pll_hold_n`=0, all `rst_n_out`=0.
  - At `cnt`==HOLD_CYC-1, go to WAIT.
- WAIT:
  - `pll_hold_n`=1.
  - If `lock_s`=1, go to FILT.
  - Else at `cnt`==LOCK_TIMEOUT-1, increment `retry_cnt`. If the new value equals MAX_RETRY, go to FAIL; otherwise go to HOLD.
- FILT:
  - If `lock_s`=0, go to WAIT. The timeout restarts from 0.
  - At `cnt`==LOCK_FILT-1 with `lock_s`=1, go to REL.
- REL:
  - Bit k of `rst_n_out` goes 1 at the edge where `cnt`==k*STAGE_GAP, for k=0..NUM_DOM-1.
  - One cycle after the last bit is released, go to RUN.
  - If `lock_s`=0 during REL, go to HOLD and clear all bits.
- RUN:
  - `sys_ready`=1. `retry_cnt` is cleared on entry.
  - If `lock_s`=0, on the same edge go to HOLD, clear all `rst_n_out` and `sys_ready`, and increment `lock_loss_cnt`.
- FAIL:
  - `pll_hold_n`=0, `pll_fail`=1, all domain resets asserted.
  - Exits only on `restart_req` (which clears `retry_cnt`) or on reset.
- `restart_req` in any state other than FAIL: go to HOLD. `retry_cnt` is unchanged and `lock_loss_cnt` is not incremented.
- Lock loss and `restart_req` in the same RUN cycle: treated as lock loss, so `lock_loss_cnt` increments.

## Timing
- Reset values:
  - state HOLD, `cnt`=0, `retry_cnt`=0, synchronizer flops=0.
  - `pll_hold_n`=0, `rst_n_out`=0, `sys_ready`=0, `pll_fail`=0, `lock_loss_cnt`=0.
- All outputs are registered. Domain resets assert asynchronously only via `pll_rst`; otherwise they change on `clkin1` edges.
- After `pll_rst` deasserts, `pll_hold_n` stays 0 for exactly HOLD_CYC cycles.
- Detection latency from a `pll_lock` rise to FILT entry: 3 cycles (2 synchronizer + 1 FSM).
- Detection latency from a `pll_lock` fall in RUN to `rst_n_out`=0: 3 cycles.
- `pll_rst` asserted mid-sequence: immediate return to reset values, whatever the current state.
- `lock_loss_cnt` saturates at 255 and never wraps.

## Configuration
- `CLK_RST_CTRL_LOSS_CNT_EN` defined: the `lock_loss_cnt` register and increment logic are built as described.
- `CLK_RST_CTRL_LOSS_CNT_EN` undefined: `lock_loss_cnt` is tied to 8'd0 and no counter logic is built. The port remains present.
- FSM behaviour is identical either way.

## Test plan
Parameters for all tests: HOLD_CYC=4, LOCK_FILT=8, LOCK_TIMEOUT=32, STAGE_GAP=2, NUM_DOM=4, MAX_RETRY=3.
- Normal bring-up:
  - Stimulus: release `pll_rst`; raise `pll_lock` 10 cycles later.
  - Required: `pll_hold_n` low for 4 cycles; `rst_n_out` goes 0001, 0011, 0111, 1111 at 2-cycle spacing; `sys_ready`=1 one cycle after 1111.
- Lock glitch in FILT:
  - Stimulus: `pll_lock` high for 5 cycles, low for 1, then high.
  - Required: FSM returns to WAIT; release starts only after 8 continuous `lock_s` cycles.
- Timeout and fail:
  - Stimulus: `pll_lock` held 0.
  - Required: three 32-cycle WAIT windows, each separated by a 4-cycle `pll_hold_n`=0 pulse; then `pll_fail`=1 and `pll_hold_n`=0 held.
  - Then pulse `restart_req` with `pll_lock`=1: `pll_fail`=0 and the sequence reaches RUN.
- Lock loss in RUN:
  - Stimulus: drop `pll_lock` for 1 cycle.
  - Required: `rst_n_out`=0000 and `sys_ready`=0 three cycles later; `lock_loss_cnt`=1 (0 with macro undefined); re-sequence to RUN.
- Simultaneous lock loss and `restart_req` in RUN:
  - Required: `lock_loss_cnt` increments by exactly 1.
- Reset mid-REL:
  - Stimulus: assert `pll_rst` when `rst_n_out`=0011.
  - Required: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_rst_ctrl.sv
// clk_rst_ctrl -- PLL bring-up and staged domain reset sequencer.
//
// Holds the PLL in reset for HOLD_CYC cycles, waits for a synchronized and
// filtered lock, then releases NUM_DOM domain resets STAGE_GAP cycles apart
// (bit 0 first). Lock is monitored in RUN; a loss re-runs the whole sequence.
// After MAX_RETRY lock timeouts the block parks in FAIL until restart_req.
//
// Ports:
//   clkin1        in   reference clock (only clock)
//   pll_rst       in   asynchronous active-low reset
//   pll_lock      in   PLL lock, asynchronous to clkin1
//   restart_req   in   single-cycle soft restart request
//   pll_hold_n    out  active-low PLL reset drive
//   rst_n_out     out  active-low domain resets [NUM_DOM-1:0]
//   sys_ready     out  high only in RUN
//   pll_fail      out  high only in FAIL
//   lock_loss_cnt out  saturating lock-loss count
//
// Build option: define CLK_RST_CTRL_LOSS_CNT_EN to build the lock-loss
// counter; otherwise lock_loss_cnt is tied to zero.
`timescale 1ns/1ps

module clk_rst_ctrl #(
  parameter int unsigned HOLD_CYC     = 16,
  parameter int unsigned LOCK_FILT    = 64,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned STAGE_GAP    = 16,
  parameter int unsigned NUM_DOM      = 4,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic               clkin1,
  input  logic               pll_rst,
  input  logic               pll_lock,
  input  logic               restart_req,
  output logic               pll_hold_n,
  output logic [NUM_DOM-1:0] rst_n_out,
  output logic               sys_ready,
  output logic               pll_fail,
  output logic [7:0]         lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_FILT,
    ST_REL,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] FILT_LAST = 16'(LOCK_FILT - 1);
  // RUN is entered one cycle after the last domain is released.
  localparam logic [15:0] REL_LAST  = 16'((NUM_DOM - 1) * STAGE_GAP + 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t             state, state_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic [3:0]         retry_cnt, retry_nxt;
  logic               lock_m, lock_s;
  logic [NUM_DOM-1:0] rel_hit;
  logic [NUM_DOM-1:0] rst_nxt;

  // Two-flop lock synchronizer.
  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Domain k is due for release when the REL phase counter reaches k*STAGE_GAP.
  for (genvar g = 0; g < NUM_DOM; g++) begin : g_rel
    assign rel_hit[g] = (cnt == 16'(g * STAGE_GAP));
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      ST_HOLD: begin
        if (!restart_req && cnt == HOLD_LAST) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (restart_req) begin
          state_nxt = ST_HOLD;
        end else if (lock_s) begin
          state_nxt = ST_FILT;
        end else if (cnt == TO_LAST) begin
          retry_nxt = retry_cnt + 4'd1;
          state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAIL : ST_HOLD;
        end
      end
      ST_FILT: begin
        if (restart_req)           state_nxt = ST_HOLD;
        else if (!lock_s)          state_nxt = ST_WAIT;
        else if (cnt == FILT_LAST) state_nxt = ST_REL;
      end
      ST_REL: begin
        if (restart_req || !lock_s) state_nxt = ST_HOLD;
        else if (cnt == REL_LAST)   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s || restart_req) state_nxt = ST_HOLD;
      end
      ST_FAIL: begin
        if (restart_req) begin
          state_nxt = ST_HOLD;
          retry_nxt = '0;
        end
      end
      default: state_nxt = ST_HOLD;
    endcase

    if (state_nxt == ST_RUN && state != ST_RUN) retry_nxt = '0;

    // A restart while already in HOLD begins a fresh hold period.
    if (state_nxt != state || (state == ST_HOLD && restart_req)) cnt_nxt = '0;
    else                                                         cnt_nxt = cnt + 16'd1;

    rst_nxt = '0;
    if (state_nxt == ST_REL || state_nxt == ST_RUN) begin
      rst_nxt = rst_n_out;
      if (state == ST_REL) rst_nxt = rst_n_out | rel_hit;
    end
  end

  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_hold_n <= 1'b0;
      rst_n_out  <= '0;
      sys_ready  <= 1'b0;
      pll_fail   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      retry_cnt  <= retry_nxt;
      pll_hold_n <= !(state_nxt == ST_HOLD || state_nxt == ST_FAIL);
      rst_n_out  <= rst_nxt;
      sys_ready  <= (state_nxt == ST_RUN);
      pll_fail   <= (state_nxt == ST_FAIL);
    end
  end

`ifdef CLK_RST_CTRL_LOSS_CNT_EN
  // Lock loss in RUN wins over a coincident restart_req, so it always counts.
  logic lock_lost;
  assign lock_lost = (state == ST_RUN) && !lock_s;

  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) begin
      lock_loss_cnt <= '0;
    end else if (lock_lost && lock_loss_cnt != '1) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
